window_spill_fill_ctrl: RTL and testbench

- Hardware window overflow/underflow sequencer for the SPARC V8 register file (8 globals + NWINDOWS×16 windowed registers).
- Control unit pulses a SAVE or RESTORE request with the current CWP and WIM.
- If the target window is invalid, the block spills 16 registers (locals+ins) to RAM, or fills them from RAM, then rotates WIM.
- Sits between ControlUnit2 and the DataPath register file / RAM port; owns both for the duration of the sequence.

---
 rtl/sparc_win_pkg.sv | 30 +++
 rtl/win_rotate.sv | 23 ++
 rtl/window_spill_fill_ctrl.sv | 140 ++++++++++++++
 tb/tb_window_spill_fill_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparc_win_pkg.sv
// Shared window geometry, sequencer state encoding and mod-N window stepping.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package sparc_win_pkg;

  localparam int NWINDOWS = 4;
  localparam int CWP_W    = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    SP_RD   = 3'd2,
    SP_WR   = 3'd3,
    FL_MEM  = 3'd4,
    FL_WR   = 3'd5,
    UPD_WIM = 3'd6,
    DONE    = 3'd7
  } state_t;

  // Next window up, wrapping NWINDOWS-1 back to 0.
  function automatic logic [CWP_W-1:0] win_inc(input logic [CWP_W-1:0] w);
    return (w == CWP_W'(NWINDOWS - 1)) ? '0 : w + CWP_W'(1);
  endfunction

  // Next window down, wrapping 0 back to NWINDOWS-1.
  function automatic logic [CWP_W-1:0] win_dec(input logic [CWP_W-1:0] w);
    return (w == '0) ? CWP_W'(NWINDOWS - 1) : w - CWP_W'(1);
  endfunction

endpackage

// File: rtl/win_rotate.sv
// Target window for a SAVE/RESTORE and the one-hot WIM marking the window beyond it.
// Latency: purely combinational.
// Backpressure: none.
module win_rotate
  import sparc_win_pkg::*;
(
  input  logic                is_save,
  input  logic [CWP_W-1:0]    cwp,
  output logic [CWP_W-1:0]    tgt,
  output logic [NWINDOWS-1:0] next_mask
);

  logic [CWP_W-1:0] beyond;

  // SAVE moves down one window, RESTORE moves up; the new invalid window is one further on.
  always_comb begin
    tgt       = is_save ? win_dec(cwp) : win_inc(cwp);
    beyond    = is_save ? win_dec(tgt) : win_inc(tgt);
    next_mask = '0;
    next_mask[beyond] = 1'b1;
  end

endmodule

// File: rtl/window_spill_fill_ctrl.sv
// Window overflow/underflow sequencer: spills or fills 16 windowed registers, then rotates WIM.
// Latency: no trap -> done 2 cycles after request; trap -> 35 cycles plus one per mem_mfc wait cycle.
// Backpressure: mem_req/addr/wdata held until mem_mfc; requests while busy are dropped.
module window_spill_fill_ctrl
  import sparc_win_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16
) (
  input  logic                Clk,
  input  logic                RESET_n,
  input  logic                save_req,
  input  logic                restore_req,
  input  logic [CWP_W-1:0]    cwp_in,
  input  logic [NWINDOWS-1:0] wim_in,
  input  logic [DATA_W-1:0]   base_addr,
  output logic                busy,
  output logic                done,
  output logic                trapped,
  output logic                err,
  output logic [CWP_W-1:0]    rf_win,
  output logic [3:0]          rf_idx,
  output logic                rf_rd_en,
  output logic                rf_wr_en,
  output logic [DATA_W-1:0]   rf_wdata,
  input  logic [DATA_W-1:0]   rf_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_mfc,
  output logic [NWINDOWS-1:0] wim_out,
  output logic                wim_we
);

  localparam int               IDX_W    = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

  state_t              state, state_n;
  logic [IDX_W-1:0]    cnt;
  logic [CWP_W-1:0]    tgt_q, req_tgt;
  logic [NWINDOWS-1:0] wim_q, wim_new_q, req_mask;
  logic [DATA_W-1:0]   base_q, data_q;
  logic                save_q, trap_q, sp_first, err_q;
  logic                accept, last;

  assign accept = (state == IDLE) && (save_req ^ restore_req);
  assign last   = (cnt == LAST_IDX);

  win_rotate u_rot (
    .is_save   (save_req),
    .cwp       (cwp_in),
    .tgt       (req_tgt),
    .next_mask (req_mask)
  );

  // Sequencer transitions; memory states stall on mem_mfc.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = CHECK;
      CHECK:   if (!wim_q[tgt_q]) state_n = DONE;
               else if (save_q)   state_n = SP_RD;
               else               state_n = FL_MEM;
      SP_RD:   state_n = SP_WR;
      SP_WR:   if (mem_mfc) state_n = last ? UPD_WIM : SP_RD;
      FL_MEM:  if (mem_mfc) state_n = FL_WR;
      FL_WR:   state_n = last ? UPD_WIM : FL_MEM;
      UPD_WIM: state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, request snapshot, word counter and the data holding register.
  always_ff @(posedge Clk or negedge RESET_n) begin
    if (!RESET_n) begin
      state     <= IDLE;
      cnt       <= '0;
      tgt_q     <= '0;
      wim_q     <= '0;
      wim_new_q <= '0;
      base_q    <= '0;
      data_q    <= '0;
      save_q    <= 1'b0;
      trap_q    <= 1'b0;
      sp_first  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state    <= state_n;
      err_q    <= (state == IDLE) && save_req && restore_req;
      sp_first <= (state == SP_RD);
      if (accept) begin
        tgt_q     <= req_tgt;
        wim_q     <= wim_in;
        wim_new_q <= req_mask;
        base_q    <= base_addr & ~DATA_W'(3);
        save_q    <= save_req;
        cnt       <= '0;
      end
      if (state == CHECK) trap_q <= wim_q[tgt_q];
      if (((state == SP_WR) && mem_mfc && !last) || ((state == FL_WR) && !last))
        cnt <= cnt + IDX_W'(1);
      // Register read data is only guaranteed in the first SP_WR cycle, so hold it for stalls.
      if ((state == SP_WR) && sp_first)
        data_q <= rf_rdata;
      else if ((state == FL_MEM) && mem_mfc)
        data_q <= mem_rdata;
    end
  end

  // Moore outputs decoded from state; everything idles at zero so reset clears them at once.
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    trapped   = (state == DONE) && trap_q;
    err       = err_q;
    rf_rd_en  = (state == SP_RD);
    rf_wr_en  = (state == FL_WR);
    rf_win    = '0;
    rf_idx    = '0;
    rf_wdata  = '0;
    mem_req   = (state == SP_WR) || (state == FL_MEM);
    mem_we    = (state == SP_WR);
    mem_addr  = '0;
    mem_wdata = '0;
    wim_we    = (state == UPD_WIM);
    wim_out   = '0;
    if (rf_rd_en || rf_wr_en) begin
      rf_win = tgt_q;
      rf_idx = cnt;
    end
    if (rf_wr_en) rf_wdata = data_q;
    if (mem_req)  mem_addr = base_q + (DATA_W'(cnt) << 2);
    if (mem_we)   mem_wdata = sp_first ? rf_rdata : data_q;
    if (wim_we)   wim_out = wim_new_q;
  end

endmodule

// File: tb/tb_window_spill_fill_ctrl.sv
// Bench for window_spill_fill_ctrl: vector table, corner sequences and randomized transactions.
// Latency: n/a.
// Backpressure: memory responder inserts per-transfer mem_mfc wait states from stall_plan.
module tb_window_spill_fill_ctrl;

  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        save_req = 1'b0, restore_req = 1'b0;
  logic [1:0]  cwp_in = '0;
  logic [3:0]  wim_in = '0;
  logic [31:0] base_addr = '0;
  logic        busy, done, trapped, err;
  logic [1:0]  rf_win;
  logic [3:0]  rf_idx;
  logic        rf_rd_en, rf_wr_en;
  logic [31:0] rf_wdata;
  logic [31:0] rf_rdata = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_mfc = 1'b0;
  logic [3:0]  wim_out;
  logic        wim_we;

  always #5 clk = ~clk;

  window_spill_fill_ctrl dut (
    .Clk(clk), .RESET_n(rst_n), .save_req(save_req), .restore_req(restore_req),
    .cwp_in(cwp_in), .wim_in(wim_in), .base_addr(base_addr),
    .busy(busy), .done(done), .trapped(trapped), .err(err),
    .rf_win(rf_win), .rf_idx(rf_idx), .rf_rd_en(rf_rd_en), .rf_wr_en(rf_wr_en),
    .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_mfc(mem_mfc), .wim_out(wim_out), .wim_we(wim_we)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          len;
    bit          unstable;
  } memx_t;

  typedef struct {
    logic [1:0]  win;
    logic [3:0]  idx;
    logic [31:0] dat;
  } rfw_t;

  typedef struct {
    logic        s;
    logic        r;
    logic [1:0]  cwp;
    logic [3:0]  wim;
    logic [31:0] base;
    logic        trap;
    logic [3:0]  nwim;
    int          lat;
    int          inj;
  } vec_t;

  memx_t       mlog[$];
  rfw_t        wlog[$];
  logic [3:0]  wimlog[$];
  int          rd_cnt = 0, err_cnt = 0, xfer_n = 0, xfer_base = 0, cyc = 0;
  int          stall_plan[16];
  logic [31:0] rf_off = 32'd100, fill_key = 32'd104;
  int          n_cmp = 0, n_bad = 0;

  bit          in_xfer = 0;
  int          stall_left = 0;
  memx_t       cur;

  // Register file: read data appears the cycle after rf_rd_en, pattern per window/index.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rf_rd_en) rf_rdata <= rf_off + 32'(rf_win) * 32'd16 + 32'(rf_idx);
  end

  // Memory responder and event logger, all sampled at the falling edge.
  always @(negedge clk) begin
    int k;
    if (in_xfer && mem_mfc) begin
      mlog.push_back(cur);
      xfer_n++;
      in_xfer = 0;
    end
    if (mem_req) begin
      if (!in_xfer) begin
        in_xfer = 1;
        k = xfer_n - xfer_base;
        stall_left = (k >= 0 && k < 16) ? stall_plan[k] : 0;
        cur.we = mem_we; cur.addr = mem_addr; cur.wdata = mem_wdata;
        cur.len = 0; cur.unstable = 0;
      end else if (mem_we !== cur.we || mem_addr !== cur.addr || mem_wdata !== cur.wdata) begin
        cur.unstable = 1;
      end
      cur.len++;
      if (stall_left > 0) begin
        mem_mfc = 1'b0;
        stall_left--;
      end else begin
        mem_mfc = 1'b1;
        mem_rdata = fill_key + (mem_addr >> 2);
      end
    end else begin
      mem_mfc = 1'b0;
      in_xfer = 0;
    end
    if (rf_wr_en) wlog.push_back('{rf_win, rf_idx, rf_wdata});
    if (rf_rd_en) rd_cnt++;
    if (wim_we) wimlog.push_back(wim_out);
    if (err) err_cnt++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Issue one request and check the whole resulting sequence against the given expectations.
  task automatic run_txn(input string nm, input logic s, input logic r, input logic [1:0] cwp,
                         input logic [3:0] wim, input logic [31:0] base, input logic exp_trap,
                         input logic [3:0] exp_wim, input int exp_lat, input int inj);
    int m0, w0, i0, rd0, e0, req_cyc, lat, t, nexp;
    logic got, tr;
    logic [31:0] a;
    m0 = mlog.size(); w0 = wlog.size(); i0 = wimlog.size(); rd0 = rd_cnt; e0 = err_cnt;
    t = (int'(cwp) + (s ? NW - 1 : 1)) % NW;
    @(negedge clk);
    xfer_base = xfer_n;
    save_req = s; restore_req = r; cwp_in = cwp; wim_in = wim; base_addr = base;
    @(posedge clk); #1;
    req_cyc = cyc;
    save_req = 0; restore_req = 0;
    cwp_in = 2'($urandom); wim_in = 4'($urandom); base_addr = $urandom;
    got = 0; lat = 0; tr = 0;
    for (int k = 0; k < 600 && !got; k++) begin
      @(negedge clk);
      if (k == inj) begin
        save_req = 1; restore_req = 1; cwp_in = 2'($urandom); wim_in = 4'hF;
      end else begin
        save_req = 0; restore_req = 0;
      end
      if (done) begin
        got = 1; lat = cyc - req_cyc + 1; tr = trapped;
      end
    end
    save_req = 0; restore_req = 0;
    chk({nm, ".done_seen"}, got, 1);
    if (got) begin
      chk({nm, ".latency"}, lat, exp_lat);
      chk({nm, ".trapped"}, tr, exp_trap);
    end
    @(negedge clk);
    chk({nm, ".busy_after"}, busy, 0);
    chk({nm, ".err_count"}, err_cnt - e0, 0);
    chk({nm, ".wim_we_count"}, wimlog.size() - i0, exp_trap);
    if (exp_trap && wimlog.size() - i0 == 1) chk({nm, ".wim_out"}, wimlog[i0], exp_wim);
    nexp = exp_trap ? 16 : 0;
    chk({nm, ".mem_xfers"}, mlog.size() - m0, nexp);
    for (int i = 0; i < nexp && m0 + i < mlog.size(); i++) begin
      a = (base & ~32'd3) + 32'(4 * i);
      chk($sformatf("%s.addr%0d", nm, i), mlog[m0 + i].addr, a);
      chk($sformatf("%s.we%0d", nm, i), mlog[m0 + i].we, s);
      chk($sformatf("%s.hold%0d", nm, i), mlog[m0 + i].len, stall_plan[i] + 1);
      chk($sformatf("%s.stable%0d", nm, i), mlog[m0 + i].unstable, 0);
      if (s) chk($sformatf("%s.wdata%0d", nm, i), mlog[m0 + i].wdata,
                 rf_off + 32'(16 * t + i));
    end
    chk({nm, ".rf_reads"}, rd_cnt - rd0, s ? nexp : 0);
    chk({nm, ".rf_writes"}, wlog.size() - w0, s ? 0 : nexp);
    if (!s) begin
      for (int i = 0; i < nexp && w0 + i < wlog.size(); i++) begin
        a = (base & ~32'd3) + 32'(4 * i);
        chk($sformatf("%s.rfw%0d", nm, i), {wlog[w0 + i].win, wlog[w0 + i].idx, wlog[w0 + i].dat},
            {2'(t), 4'(i), fill_key + (a >> 2)});
      end
    end
  endtask

  vec_t vt[9];

  initial begin
    int m0, i0, sum, t, e0;
    logic s, trap, found;
    logic [1:0] cwp;
    logic [3:0] wim, nwim;
    logic [31:0] base;

    foreach (stall_plan[i]) stall_plan[i] = 0;
    vt[0] = '{1, 0, 2'd2, 4'b0001, 32'h180, 0, 4'b0000, 2, -1};
    vt[1] = '{1, 0, 2'd1, 4'b0001, 32'h180, 1, 4'b1000, 35, -1};
    vt[2] = '{0, 1, 2'd3, 4'b0001, 32'h180, 1, 4'b0010, 35, -1};
    vt[3] = '{1, 0, 2'd0, 4'b1000, 32'h183, 1, 4'b0100, 35, -1};
    vt[4] = '{0, 1, 2'd3, 4'b1110, 32'h180, 0, 4'b0000, 2, -1};
    vt[5] = '{1, 0, 2'd1, 4'b0000, 32'h180, 0, 4'b0000, 2, -1};
    vt[6] = '{0, 1, 2'd2, 4'b1000, 32'hFFFF_FFF4, 1, 4'b0001, 35, -1};
    vt[7] = '{1, 0, 2'd1, 4'b0001, 32'h180, 1, 4'b1000, 35, 8};
    vt[8] = '{0, 1, 2'd0, 4'b0010, 32'h200, 1, 4'b0100, 35, -1};

    repeat (2) @(negedge clk);
    chk("reset.ctrl", {busy, done, trapped, err, rf_rd_en, rf_wr_en, mem_req, mem_we, wim_we}, 0);
    chk("reset.data", |{mem_addr, mem_wdata, rf_wdata, wim_out, rf_win, rf_idx}, 0);
    rst_n = 1;

    for (int v = 0; v < 9; v++)
      run_txn($sformatf("vec%0d", v), vt[v].s, vt[v].r, vt[v].cwp, vt[v].wim, vt[v].base,
              vt[v].trap, vt[v].nwim, vt[v].lat, vt[v].inj);

    // Three wait states on the sixth spill word.
    stall_plan[5] = 3;
    run_txn("mfc_wait", 1, 0, 2'd1, 4'b0001, 32'h180, 1, 4'b1000, 38, -1);
    stall_plan[5] = 0;

    // Conflicting requests in IDLE.
    e0 = err_cnt;
    @(negedge clk);
    save_req = 1; restore_req = 1; cwp_in = 2'd1; wim_in = 4'b0001;
    @(posedge clk); #1;
    save_req = 0; restore_req = 0;
    @(negedge clk);
    chk("conflict.err_hi", err, 1);
    chk("conflict.busy", busy, 0);
    @(negedge clk);
    chk("conflict.err_lo", err, 0);
    chk("conflict.busy2", busy, 0);
    chk("conflict.err_pulses", err_cnt - e0, 1);

    // Reset in the middle of the idx 7 spill write, which is stalled.
    stall_plan[7] = 6;
    m0 = mlog.size(); i0 = wimlog.size();
    @(negedge clk);
    xfer_base = xfer_n;
    save_req = 1; cwp_in = 2'd1; wim_in = 4'b0001; base_addr = 32'h180;
    @(posedge clk); #1;
    save_req = 0;
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 32'h19C) found = 1;
    end
    chk("midreset.reached_idx7", found, 1);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("midreset.ctrl", {busy, done, trapped, err, rf_rd_en, rf_wr_en, mem_req, mem_we, wim_we}, 0);
    chk("midreset.data", |{mem_addr, mem_wdata, rf_wdata, wim_out, rf_win, rf_idx}, 0);
    repeat (3) @(negedge clk);
    chk("midreset.xfers_done", mlog.size() - m0, 7);
    chk("midreset.no_wim_we", wimlog.size() - i0, 0);
    rst_n = 1;
    stall_plan[7] = 0;
    run_txn("after_reset", 1, 0, 2'd1, 4'b0001, 32'h180, 1, 4'b1000, 35, -1);

    // Randomized transactions against the rule-level model.
    for (int n = 0; n < 30; n++) begin
      s    = 1'($urandom_range(0, 1));
      cwp  = 2'($urandom);
      wim  = 4'($urandom);
      base = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFC0 | 32'($urandom_range(0, 63))) : $urandom;
      rf_off   = $urandom;
      fill_key = $urandom;
      sum = 0;
      for (int i = 0; i < 16; i++) begin
        stall_plan[i] = $urandom_range(0, 2);
        sum += stall_plan[i];
      end
      t    = (int'(cwp) + (s ? NW - 1 : 1)) % NW;
      trap = wim[t];
      nwim = 4'(1 << ((t + (s ? NW - 1 : 1)) % NW));
      run_txn($sformatf("rnd%0d", n), s, ~s, cwp, wim, base, trap, nwim,
              trap ? 35 + sum : 2, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
